// File: rtl/gate_stream_accum_if.sv
// Stream bundle for gate_stream_accum: input word stream plus registered result handshake.
// out_parity exists only when GATE_STREAM_PARITY_EN is defined.
interface gate_stream_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
`ifdef GATE_STREAM_PARITY_EN
    logic             out_parity;
`endif

    // A word moves when in_valid && in_ready at a rising edge; a result moves
    // when out_valid && out_ready at a rising edge. Neither ready depends on its valid.
    modport master (
        output op, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
`ifdef GATE_STREAM_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
`ifdef GATE_STREAM_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/gate_stream_accum.sv
// Folds a packet of words with a selectable bitwise gate and presents the result, beat count
// and overflow on a registered handshake. Optional out_parity under GATE_STREAM_PARITY_EN.
module gate_stream_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_stream_accum_if.slave   bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic [2:0]       r_op;
    logic [2:0]       w_op_eff;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_result;
    logic             w_inv;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = bus.in_last ? HOLD : ACCUM;
            ACCUM:   if (w_accept && bus.in_last) w_state_next = HOLD;
            HOLD:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Ready/valid are pure decodes of the state register, never of out_ready.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE, ACCUM: w_in_ready  = 1'b1;
            HOLD:        w_out_valid = 1'b1;
            default:     ;
        endcase
    end

    // The first beat takes op straight from the port; later beats use the latched copy.
    assign w_op_eff = (r_state == IDLE) ? bus.op : r_op;
    assign w_inv    = (w_op_eff == 3'b011) || (w_op_eff == 3'b100) || (w_op_eff == 3'b101);

    always_comb begin
        w_acc_next = bus.in_data;
        if (r_state != IDLE) begin
            case (r_op)
                3'b001, 3'b100: w_acc_next = r_acc | bus.in_data;
                3'b010, 3'b101: w_acc_next = r_acc ^ bus.in_data;
                3'b110:         w_acc_next = bus.in_data;
                default:        w_acc_next = r_acc & bus.in_data;
            endcase
        end
    end

    assign w_result = w_inv ? ~w_acc_next : w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= 3'b000;
            r_acc      <= '0;
            r_out_data <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_out_data <= w_result;
            if (r_state == IDLE) begin
                r_op    <= bus.op;
                r_count <= CNT_ONE;
                r_ovf   <= 1'b0;
            end else if (r_count == CNT_MAX) begin
                r_ovf   <= 1'b1;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

`ifdef GATE_STREAM_PARITY_EN
    logic r_parity;
    always_ff @(posedge clk) begin
        if (!rst_n)        r_parity <= 1'b0;
        else if (w_accept) r_parity <= ^w_result;
    end
    assign bus.out_parity = r_parity;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_ovf;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_gate_stream_accum.sv
// Bench for gate_stream_accum: directed packets then random packets, checked by a
// queue-based scoreboard fed from a fold model of the gate rules.
module tb_gate_stream_accum;
    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int EW   = W + CW + 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    gate_stream_accum_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    gate_stream_accum #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int             checks   = 0;
    int             failures = 0;
    int             rdy_mode = 0;
    bit             gaps_en  = 0;
    logic [W-1:0]   words[$];
    logic [EW-1:0]  exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // reference model: fold the whole packet with the gate rules
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] w[$]);
        logic [W-1:0] acc;
        int           n;
        n   = w.size();
        acc = w[0];
        for (int i = 1; i < n; i++) begin
            case (op)
                3'd1, 3'd4: acc = acc | w[i];
                3'd2, 3'd5: acc = acc ^ w[i];
                3'd6:       acc = w[i];
                default:    acc = acc & w[i];
            endcase
        end
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) acc = ~acc;
        return {acc, CW'((n > CMAX) ? CMAX : n), (n > CMAX), ^acc};
    endfunction

    // driver
    task automatic wait_accept();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 200);
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [2:0] op0, input int later_op, input bit complete);
        int n;
        n = words.size();
        if (complete) exp_q.push_back(model(op0, words));
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            bus.in_last  = complete && (i == n - 1);
            if (i == 0)            bus.op = op0;
            else if (later_op < 0) bus.op = 3'($urandom_range(0, 7));
            else                   bus.op = 3'(later_op);
            wait_accept();
            bus.in_valid = 1'b0;
            bus.in_data  = W'($urandom);
            bus.in_last  = 1'($urandom);
            bus.op       = 3'($urandom_range(0, 7));
            if (complete && i == n - 1) check("latency_out_valid", 32'(bus.out_valid), 1);
            else if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    // out_ready generator for the free-running modes
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      bus.out_ready = 1'b1;
            else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // monitor / scoreboard
    logic [EW-1:0] held;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    bit            prev_stall = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else if (bus.out_valid) begin
            got = {bus.out_data, bus.out_count, bus.out_ovf, 1'b0};
            check("hold_in_ready", 32'(bus.in_ready), 0);
            if (prev_stall) check("stable_outputs", 32'(got), 32'(held));
            if (bus.out_ready) begin
                prev_stall = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%0h required=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data",  32'(bus.out_data),  32'(e[EW-1 -: W]));
                    check("out_count", 32'(bus.out_count), 32'(e[CW+1:2]));
                    check("out_ovf",   32'(bus.out_ovf),   32'(e[1]));
`ifdef GATE_STREAM_PARITY_EN
                    check("out_parity", 32'(bus.out_parity), 32'(e[0]));
`endif
                end
            end else begin
                prev_stall = 1;
                held       = got;
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_data"},  32'(bus.out_data),  0);
        check({tag, "_out_count"}, 32'(bus.out_count), 0);
        check({tag, "_out_ovf"},   32'(bus.out_ovf),   0);
        check({tag, "_state"},     32'(dbg_state),     0);
`ifdef GATE_STREAM_PARITY_EN
        check({tag, "_out_parity"}, 32'(bus.out_parity), 0);
`endif
    endtask

    // stimulus
    initial begin
        int t;
        int n;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.op       = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("reset");

        words = '{8'hF0, 8'h3C, 8'hFF};
        send_packet(3'd0, -1, 1'b1);

        words = '{8'hA5};
        send_packet(3'd3, -1, 1'b1);

        // consumer stalls three cycles on an XOR result
        rdy_mode = 2;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        words = '{8'h0F, 8'hF0, 8'hFF};
        send_packet(3'd2, -1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("stall_out_data", 32'(bus.out_data), 0);
            check("stall_in_ready", 32'(bus.in_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("after_stall_in_ready", 32'(bus.in_ready), 1);
        check("after_stall_state",    32'(dbg_state),    0);
        rdy_mode = 0;

        words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        send_packet(3'd1, -1, 1'b1);

        words = '{8'h01, 8'h02};
        send_packet(3'd1, 0, 1'b1);

        // reset in the middle of a packet discards it
        words = '{8'hAA, 8'h0F};
        send_packet(3'd0, -1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("midreset");

        words = '{8'h55};
        send_packet(3'd2, -1, 1'b1);

        rdy_mode = 1;
        gaps_en  = 1;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 6);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(W'($urandom));
            send_packet(3'($urandom_range(0, 7)), -1, 1'b1);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
